pattern_tx: RTL and testbench
=============================

PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 Parameter BIT_DIV, default 13500000, is the number of clk cycles per transmitted bit (legal 2..2^24-1).
REQ-002 Parameter WIDTH, default 6, is the number of data bits per frame.
REQ-003 clk  input  1  the single system clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  synchronous reset, active-low.
REQ-005 load  input  1  one-cycle request to send data_in; it SHALL be accepted only while ready=1.
REQ-006 data_in  input  WIDTH  parallel word to serialise, captured on the accepted load.
REQ-007 ready  output  1  high when in IDLE and able to accept a load.
REQ-008 tx_out  output  1  serial line, active-low: logical 1 drives 0, idle/logical 0 drives 1.
REQ-009 led  output  WIDTH  active-low view of the shift register (led = ~shreg).

Function
REQ-010 FSM states SHALL be IDLE, START, DATA and STOP; one bit period equals BIT_DIV clk cycles.
REQ-011 IDLE: tx_out=1 and ready=1; an accepted load captures data_in into shreg, clears the bit-period counter and bit index, and moves to START.
REQ-012 Latency: for a load accepted at edge N, tx_out SHALL go low (start bit, logical 1) from edge N, i.e. visible in cycle N+1.
REQ-013 START SHALL last one bit period and then move to DATA.
REQ-014 DATA SHALL send WIDTH bits MSB first, one per bit period, with tx_out = ~shreg[WIDTH-1]; shreg SHALL shift left with a 0 fill at each bit boundary.
REQ-015 After WIDTH data bits the FSM SHALL move to STOP; STOP SHALL hold tx_out=1 for one bit period and then return to IDLE.
REQ-016 A full frame SHALL be (WIDTH+2)*BIT_DIV cycles; ready SHALL rise on the cycle after STOP ends.
REQ-017 The bit-period counter SHALL be 24 bits wide, count 0..BIT_DIV-1 and wrap to 0; it SHALL be held at 0 in IDLE.
REQ-018 A load while ready=0 SHALL be ignored with no effect on the frame in progress, including a load on the final STOP cycle.
REQ-019 data_in changes after acceptance SHALL NOT affect the frame in progress.
REQ-020 The bit index SHALL count 0..WIDTH-1 and SHALL never wrap inside a frame.

Reset
REQ-021 When rst_n=0 at a clk edge: state=IDLE, shreg=0, counter=0, and index=0.
REQ-022 Reset outputs SHALL be ready=1, tx_out=1 and led all-ones.
REQ-023 A reset mid-frame SHALL abort the frame; tx_out SHALL read 1 from the next edge and no partial bits SHALL follow.
REQ-024 A load in the same cycle as rst_n=0 SHALL be ignored.

Configuration
REQ-025 Macro PATTERN_TX_LOOP_EN defined: at the end of STOP the FSM SHALL reload the last accepted word and start a new frame immediately, with ready held 0 while looping.
REQ-026 Under PATTERN_TX_LOOP_EN, only reset SHALL end looping, and a load while looping SHALL be ignored.
REQ-027 Macro PATTERN_TX_LOOP_EN undefined: frames SHALL be one-shot per REQ-015, and no word-holding register SHALL be synthesised.

Structure
REQ-028 Package pattern_tx_pkg SHALL hold the state enum, the default BIT_DIV and WIDTH values, and the counter width constant (24).
REQ-029 Sub-module bit_tick SHALL contain the bit-period counter and emit a one-cycle tick at count BIT_DIV-1; it SHALL have a synchronous clear input.
REQ-030 pattern_tx SHALL instantiate exactly one bit_tick.

Verification (BIT_DIV=4, WIDTH=6)
REQ-031 Load 6'b101100 from idle -> tx_out held 4 cycles each at 0 (start), then 0,1,0,0,1,1 for bits 1,0,1,1,0,0, then 1 (stop); ready returns 1 after 32 cycles.
REQ-032 Second load at cycle 10 of a frame carrying 6'b000001 -> frame unchanged and the second word never transmitted.
REQ-033 rst_n=0 for one cycle at cycle 13 of a frame -> next cycle shows tx_out=1, ready=1 and led=6'b111111, with no further transitions.
REQ-034 Load 6'b111111 then change data_in to 0 the next cycle -> all six data bits transmit as tx_out=0.
REQ-035 With PATTERN_TX_LOOP_EN, load 6'b100000 -> frames repeat back-to-back every 32 cycles with ready=0 throughout.
REQ-036 load and rst_n=0 asserted in the same cycle -> module remains IDLE with tx_out=1.

Source files
------------

// File: rtl/pattern_tx_pkg.sv
// pattern_tx_pkg: shared types and defaults for the pattern_tx serialiser.
// Build option: PATTERN_TX_LOOP_EN (see pattern_tx.sv).
package pattern_tx_pkg;

    localparam int DEF_BIT_DIV = 13500000;
    localparam int DEF_WIDTH   = 6;
    localparam int CNT_W       = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/bit_tick.sv
// bit_tick: free-running bit-period counter (0..BIT_DIV-1) with a one-cycle
// tick on the last count of each period and a synchronous clear.
module bit_tick
    import pattern_tx_pkg::*;
#(
    parameter int BIT_DIV = DEF_BIT_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Count clk cycles within a bit period; clear holds the count at zero.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/pattern_tx.sv
// pattern_tx: active-low serial frame transmitter (start, WIDTH data bits MSB
// first, stop), one bit every BIT_DIV clk cycles, with an active-low LED view
// of the shift register.
// Build option PATTERN_TX_LOOP_EN: replay the last accepted word back-to-back
// until reset; without it every frame is one-shot.
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int BIT_DIV = DEF_BIT_DIV,
    parameter int WIDTH   = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             tx_out,
    output logic [WIDTH-1:0] led
);

    localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [IDX_W-1:0] idx;
    logic             tick;
    logic             cnt_clr;

`ifdef PATTERN_TX_LOOP_EN
    logic [WIDTH-1:0] hold;
`endif

    // The period counter only runs while a frame is in flight, so the first
    // tick after acceptance lands exactly one bit period later.
    assign cnt_clr    = (state == IDLE);
    assign shreg_next = shreg << 1;
    assign led        = ~shreg;

    bit_tick #(
        .BIT_DIV (BIT_DIV)
    ) u_bit_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .tick  (tick)
    );

    // Frame sequencer: tx_out and ready are registered alongside the state so
    // the start bit appears on the same edge that accepts the load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            shreg  <= '0;
            idx    <= '0;
            tx_out <= 1'b1;
            ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg  <= data_in;
`ifdef PATTERN_TX_LOOP_EN
                        hold   <= data_in;
`endif
                        idx    <= '0;
                        state  <= START;
                        tx_out <= 1'b0;
                        ready  <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        state  <= DATA;
                        tx_out <= ~shreg[WIDTH-1];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg <= shreg_next;
                        if (idx == LAST_IDX) begin
                            state  <= STOP;
                            tx_out <= 1'b1;
                        end else begin
                            idx    <= idx + 1'b1;
                            tx_out <= ~shreg_next[WIDTH-1];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
`ifdef PATTERN_TX_LOOP_EN
                        shreg  <= hold;
                        idx    <= '0;
                        state  <= START;
                        tx_out <= 1'b0;
`else
                        state  <= IDLE;
                        ready  <= 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx: randomized and directed stimulus for pattern_tx
// (BIT_DIV=4, WIDTH=6) checked against a frame-level reference model.
module tb_pattern_tx;

    localparam int BD    = 4;
    localparam int W     = 6;
    localparam int FRAME = (W + 2) * BD;
`ifdef PATTERN_TX_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         load    = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         ready;
    logic         tx_out;
    logic [W-1:0] led;

    int n_tests = 0;
    int n_fail  = 0;

    pattern_tx #(
        .BIT_DIV (BD),
        .WIDTH   (W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .data_in (data_in),
        .ready   (ready),
        .tx_out  (tx_out),
        .led     (led)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is "busy" for FRAME cycles after acceptance;
    // k counts cycles since the accepting edge.
    bit           m_busy = 1'b0;
    int           m_k    = 0;
    logic [W-1:0] m_word = '0;
    bit           chk_en = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_k    = 0;
            chk_en = 1'b1;
        end else if (m_busy) begin
            m_k++;
            if (m_k == FRAME) begin
                if (LOOP) m_k = 0;
                else      m_busy = 1'b0;
            end
        end else if (load) begin
            m_busy = 1'b1;
            m_k    = 0;
            m_word = data_in;
        end
    end

    function automatic logic exp_tx(input bit busy, input int k, input logic [W-1:0] w);
        int p;
        p = k / BD;
        if (!busy)  return 1'b1;
        if (p == 0) return 1'b0;
        if (p <= W) return ~w[W-p];
        return 1'b1;
    endfunction

    function automatic logic [W-1:0] exp_led(input bit busy, input int k, input logic [W-1:0] w);
        int p;
        logic [W-1:0] s;
        p = k / BD;
        if (!busy)       s = '0;
        else if (p == 0) s = w;
        else if (p <= W) s = w << (p - 1);
        else             s = '0;
        return ~s;
    endfunction

    // Compare every cycle once reset has been seen.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_tx",    {31'd0, tx_out}, {31'd0, exp_tx(m_busy, m_k, m_word)});
            check("model_ready", {31'd0, ready},  {31'd0, ~m_busy});
            check("model_led",   {26'd0, led},    {26'd0, exp_led(m_busy, m_k, m_word)});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        logic [7:0] lit_tx;
        lit_tx = 8'b11100100;   // per bit period: start, 1,0,1,1,0,0, stop (active-low)

        // Reset state and first frame of 6'b101100
        do_reset();
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_tx",    {31'd0, tx_out}, 32'd1);
        check("rst_led",   {26'd0, led}, 32'h3f);
        data_in = 6'b101100;
        load    = 1'b1;
        step(1);
        load    = 1'b0;
        check("lit_led_start", {26'd0, led}, 32'h13);
        for (int j = 0; j < FRAME; j++) begin
            check("lit_tx_frame", {31'd0, tx_out}, {31'd0, lit_tx[j/BD]});
            if (j == FRAME - 1) check("lit_ready_last", {31'd0, ready}, 32'd0);
            step(1);
        end
        check("lit_ready_end", {31'd0, ready}, {31'd0, ~LOOP});
        check("lit_tx_end",    {31'd0, tx_out}, {31'd0, ~LOOP});

        // Load during a busy frame is ignored
        do_reset();
        data_in = 6'b110010;
        load    = 1'b1;
        step(1);
        load    = 1'b0;
        step(9);
        data_in = 6'b000001;
        load    = 1'b1;
        step(1);
        load    = 1'b0;
        step(FRAME);

        // Reset mid-frame aborts with no trailing bits
        do_reset();
        data_in = 6'b101101;
        load    = 1'b1;
        step(1);
        load    = 1'b0;
        step(12);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check("abort_tx",    {31'd0, tx_out}, 32'd1);
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_led",   {26'd0, led}, 32'h3f);
        for (int j = 0; j < 40; j++) begin
            check("abort_idle_tx", {31'd0, tx_out}, 32'd1);
            step(1);
        end

        // data_in changes after acceptance do not affect the frame
        do_reset();
        data_in = 6'b111111;
        load    = 1'b1;
        step(1);
        load    = 1'b0;
        data_in = 6'b000000;
        step(BD);
        for (int j = 0; j < W * BD; j++) begin
            check("ones_data_tx", {31'd0, tx_out}, 32'd0);
            step(1);
        end
        check("ones_stop_tx", {31'd0, tx_out}, 32'd1);
        step(BD);

        // load together with reset is ignored
        do_reset();
        rst_n   = 1'b0;
        load    = 1'b1;
        data_in = 6'b101010;
        step(1);
        rst_n = 1'b1;
        load  = 1'b0;
        check("ldrst_ready", {31'd0, ready}, 32'd1);
        check("ldrst_tx",    {31'd0, tx_out}, 32'd1);
        step(5);
        check("ldrst_ready_later", {31'd0, ready}, 32'd1);

`ifdef PATTERN_TX_LOOP_EN
        // Looping replays 6'b100000 back-to-back
        do_reset();
        data_in = 6'b100000;
        load    = 1'b1;
        step(1);
        load    = 1'b0;
        for (int j = 0; j < 3 * FRAME; j++) begin
            check("loop_ready", {31'd0, ready}, 32'd0);
            check("loop_tx", {31'd0, tx_out}, {31'd0, ((j % FRAME) / BD == 1 || (j % FRAME) / BD >= W + 1) ? 1'b0 ^ ((j % FRAME) / BD >= W + 1) : ((j % FRAME) / BD != 0)});
            step(1);
        end
`endif

        // Randomized traffic with occasional resets
        do_reset();
        for (int j = 0; j < 2000; j++) begin
            load    = ($urandom_range(0, 9) == 0);
            data_in = W'($urandom);
            rst_n   = ($urandom_range(0, 299) != 0);
            step(1);
        end
        rst_n = 1'b1;
        load  = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
